serial_frame_deserializer: RTL and testbench

//  Downstream consumer of the 8-bit PISO shift-register stage. Takes its MSB-first

---
 rtl/serial_frame_deserializer_if.sv | 56 +++++
 rtl/serial_frame_deserializer.sv | 157 +++++++++++++++
 tb/tb_serial_frame_deserializer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_deserializer_if.sv
// -----------------------------------------------------------------------------
// serial_frame_deserializer_if
//
// Purpose:
//   Bundles the serial input side and the parallel word output side of the
//   serial frame deserializer into a single interface. Clock and reset are
//   kept as plain ports on the modules that use this interface.
//
// Signals:
//   SI      serial data bit, MSB of each word first
//   SVALID  SI carries a valid bit this cycle
//   RESYNC  one-cycle pulse: drop alignment and hunt for the sync word again
//   DOUT    assembled word, stable while DVALID=1
//   DVALID  DOUT holds an unconsumed word
//   DREADY  consumer accepts DOUT when DVALID&DREADY at the clock edge
//   LOCK    1 while word alignment is established
//   OVF     sticky flag: a completed word was dropped because DOUT was full
//
// Modports:
//   master  the environment: drives the serial stream and the consumer ready
//   slave   the deserializer itself
// -----------------------------------------------------------------------------
interface serial_frame_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             SI;
    logic             SVALID;
    logic             RESYNC;
    logic [WIDTH-1:0] DOUT;
    logic             DVALID;
    logic             DREADY;
    logic             LOCK;
    logic             OVF;

    modport master (
        output SI,
        output SVALID,
        output RESYNC,
        output DREADY,
        input  DOUT,
        input  DVALID,
        input  LOCK,
        input  OVF
    );

    modport slave (
        input  SI,
        input  SVALID,
        input  RESYNC,
        input  DREADY,
        output DOUT,
        output DVALID,
        output LOCK,
        output OVF
    );
endinterface

// File: rtl/serial_frame_deserializer.sv
// -----------------------------------------------------------------------------
// serial_frame_deserializer
//
// Purpose:
//   Consumes an MSB-first serial bit stream, hunts for a sync word to find the
//   word boundary, then reassembles WIDTH-bit words into a single holding
//   register offered to a downstream consumer with a valid/ready handshake.
//   The sync word that establishes alignment is never forwarded; once locked,
//   a word equal to the sync pattern is ordinary data.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   SYNC_WORD  alignment pattern, WIDTH bits wide
//
// Ports:
//   C    clock, all logic on its rising edge
//   R    synchronous reset, active-high, overrides every other input
//   bus  serial_frame_deserializer_if.slave: SI/SVALID/RESYNC in,
//        DOUT/DVALID out, DREADY in, LOCK/OVF out
// -----------------------------------------------------------------------------
module serial_frame_deserializer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5
) (
    input  logic                          C,
    input  logic                          R,
    serial_frame_deserializer_if.slave    bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   win_q,    win_d;
    // In HUNT: fill count of the window since entering HUNT (saturating).
    // In LOCKED: number of bits of the current word received so far.
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0]   dout_q,   dout_d;
    logic               dvalid_q, dvalid_d;
    logic               ovf_q,    ovf_d;

    // Window as it would look after shifting in this cycle's SI. Both the
    // sync comparison and the completed word are taken from this value so
    // that the last bit of a word is used in the same cycle it arrives.
    logic [WIDTH-1:0]   shifted;
    logic               sync_match;
    logic               word_done;
    logic               accept;

    assign shifted = {win_q[WIDTH-2:0], bus.SI};
    assign accept  = dvalid_q & bus.DREADY;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge C) begin
        if (R) begin
            state_q  <= ST_HUNT;
            win_q    <= '0;
            bitcnt_q <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            bitcnt_q <= bitcnt_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        bitcnt_d   = bitcnt_q;
        dout_d     = dout_q;
        dvalid_d   = dvalid_q;
        ovf_d      = ovf_q;
        sync_match = 1'b0;
        word_done  = 1'b0;

        if (bus.RESYNC) begin
            // Alignment and any partial word are thrown away, including the
            // bit presented this cycle. The holding register is left alone so
            // a word already offered can still be consumed below.
            state_d  = ST_HUNT;
            win_d    = '0;
            bitcnt_d = '0;
        end else if (bus.SVALID) begin
            win_d = shifted;
            unique case (state_q)
                ST_HUNT: begin
                    // Only compare once the window holds a full word of bits
                    // received since entering HUNT; stale zeros must not be
                    // able to complete a match.
                    sync_match = (bitcnt_q >= CNT_LAST) && (shifted == SYNC_WORD);
                    if (sync_match) begin
                        state_d  = ST_LOCKED;
                        bitcnt_d = '0;
                    end else if (bitcnt_q < CNT_FULL) begin
                        bitcnt_d = bitcnt_q + CNT_ONE;
                    end
                end
                ST_LOCKED: begin
                    if (bitcnt_q == CNT_LAST) begin
                        word_done = 1'b1;
                        bitcnt_d  = '0;
                    end else begin
                        bitcnt_d  = bitcnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d  = ST_HUNT;
                    bitcnt_d = '0;
                end
            endcase
        end

        // Holding register. A completion on the same edge as an accept
        // replaces the word in place, so DVALID never drops in between.
        if (word_done) begin
            if (!dvalid_q || accept) begin
                dout_d   = shifted;
                dvalid_d = 1'b1;
            end else begin
                ovf_d    = 1'b1;
            end
        end else if (accept) begin
            dvalid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.DOUT   = dout_q;
    assign bus.DVALID = dvalid_q;
    assign bus.LOCK   = (state_q == ST_LOCKED);
    assign bus.OVF    = ovf_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
module tb_serial_frame_deserializer;

    logic C;
    logic R;
    int   n_checks;
    int   n_fail;
    bit   saw_sync_out;

    serial_frame_deserializer_if #(.WIDTH(8)) ifc ();

    serial_frame_deserializer #(
        .WIDTH     (8),
        .SYNC_WORD (8'hA5)
    ) dut (
        .C   (C),
        .R   (R),
        .bus (ifc.slave)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    // The sync word must never appear on DOUT anywhere in this run.
    always @(negedge C) begin
        if (!R && ifc.DVALID && ifc.DOUT == 8'hA5) saw_sync_out <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are set at a falling edge, sampled on the rising edge,
    // and outputs are read back at the following falling edge.
    task automatic tick();
        @(posedge C);
        @(negedge C);
    endtask

    task automatic send_bit(input logic b);
        ifc.SI     = b;
        ifc.SVALID = 1'b1;
        tick();
    endtask

    // Sends a byte MSB first. With gaps set, 1..3 idle cycles follow every
    // bit except the last. With rdy_last set, DREADY is raised for the edge
    // carrying the last bit.
    task automatic send_byte(input logic [7:0] v, input bit gaps, input bit rdy_last);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && rdy_last) ifc.DREADY = 1'b1;
            send_bit(v[i]);
            if (gaps && i != 0) begin
                ifc.SVALID = 1'b0;
                repeat ((i % 3) + 1) tick();
            end
        end
    endtask

    task automatic idle();
        ifc.SVALID = 1'b0;
        tick();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        saw_sync_out = 1'b0;
        R          = 1'b1;
        ifc.SI     = 1'b0;
        ifc.SVALID = 1'b0;
        ifc.RESYNC = 1'b0;
        ifc.DREADY = 1'b0;
        @(negedge C);
        tick();
        tick();
        R = 1'b0;

        // Reset state
        chk("rst_dout",   ifc.DOUT,   8'h00);
        chk("rst_dvalid", ifc.DVALID, 1'b0);
        chk("rst_lock",   ifc.LOCK,   1'b0);
        chk("rst_ovf",    ifc.OVF,    1'b0);

        // Lock on A5, then 3C delivered for exactly one cycle
        ifc.DREADY = 1'b1;
        send_byte(8'hA5, 1'b0, 1'b0);
        chk("t2_lock",        ifc.LOCK,   1'b1);
        chk("t2_no_sync_out", ifc.DVALID, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        chk("t2_dvalid", ifc.DVALID, 1'b1);
        chk("t2_dout",   ifc.DOUT,   8'h3C);
        idle();
        chk("t2_dvalid_1cyc", ifc.DVALID, 1'b0);

        // Backpressure: 11 held, 22 dropped, OVF sticky across an accept
        ifc.DREADY = 1'b0;
        send_byte(8'h11, 1'b0, 1'b0);
        chk("t4_dvalid_11", ifc.DVALID, 1'b1);
        chk("t4_dout_11",   ifc.DOUT,   8'h11);
        chk("t4_ovf_pre",   ifc.OVF,    1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        chk("t4_dout_held", ifc.DOUT,   8'h11);
        chk("t4_dvalid",    ifc.DVALID, 1'b1);
        chk("t4_ovf",       ifc.OVF,    1'b1);
        ifc.SVALID = 1'b0;
        ifc.DREADY = 1'b1;
        tick();
        ifc.DREADY = 1'b0;
        chk("t4_accept_dvalid", ifc.DVALID, 1'b0);
        chk("t4_accept_dout",   ifc.DOUT,   8'h11);
        chk("t4_ovf_sticky",    ifc.OVF,    1'b1);
        tick();
        chk("t4_ovf_sticky2",   ifc.OVF,    1'b1);

        // Put a word back in the holding register, then reset mid-word
        send_byte(8'h44, 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        R = 1'b1;
        tick();
        tick();
        R = 1'b0;
        ifc.SVALID = 1'b0;
        chk("t1_dout",   ifc.DOUT,   8'h00);
        chk("t1_dvalid", ifc.DVALID, 1'b0);
        chk("t1_lock",   ifc.LOCK,   1'b0);
        chk("t1_ovf",    ifc.OVF,    1'b0);
        // A non-sync byte must not be delivered: alignment has to be re-found
        send_byte(8'h3C, 1'b0, 1'b0);
        chk("t1_rehunt_lock",   ifc.LOCK,   1'b0);
        chk("t1_rehunt_dvalid", ifc.DVALID, 1'b0);

        // Seven bits straight after reset must not lock
        R = 1'b1;
        ifc.SVALID = 1'b0;
        tick();
        R = 1'b0;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("t3_fill_nolock", ifc.LOCK, 1'b0);

        // Junk 1,0,1 then A5: lock only at the A5 boundary
        R = 1'b1;
        ifc.SVALID = 1'b0;
        tick();
        R = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("t3_no_early_lock", ifc.LOCK, 1'b0);
        send_bit(1'b1);
        chk("t3_lock", ifc.LOCK, 1'b1);
        ifc.DREADY = 1'b1;
        send_byte(8'h5A, 1'b0, 1'b0);
        chk("t3_dvalid", ifc.DVALID, 1'b1);
        chk("t3_dout",   ifc.DOUT,   8'h5A);
        idle();
        chk("t3_consumed", ifc.DVALID, 1'b0);

        // Accept and completion on the same edge, back to back
        ifc.DREADY = 1'b0;
        send_byte(8'h11, 1'b0, 1'b0);
        chk("t5_dout_11", ifc.DOUT, 8'h11);
        send_byte(8'h22, 1'b0, 1'b1);
        chk("t5_dvalid", ifc.DVALID, 1'b1);
        chk("t5_dout",   ifc.DOUT,   8'h22);
        chk("t5_ovf",    ifc.OVF,    1'b0);
        idle();
        chk("t5_consumed", ifc.DVALID, 1'b0);

        // Same again with idle cycles between bits
        ifc.DREADY = 1'b0;
        send_byte(8'h11, 1'b1, 1'b0);
        chk("t5g_dout_11", ifc.DOUT,   8'h11);
        chk("t5g_lock",    ifc.LOCK,   1'b1);
        send_byte(8'h22, 1'b1, 1'b1);
        chk("t5g_dvalid", ifc.DVALID, 1'b1);
        chk("t5g_dout",   ifc.DOUT,   8'h22);
        chk("t5g_ovf",    ifc.OVF,    1'b0);
        ifc.DREADY = 1'b0;

        // RESYNC three bits into a word, with 22 still held
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        ifc.RESYNC = 1'b1;
        send_bit(1'b1);
        ifc.RESYNC = 1'b0;
        ifc.SVALID = 1'b0;
        chk("t6_unlock",      ifc.LOCK,   1'b0);
        chk("t6_held_dvalid", ifc.DVALID, 1'b1);
        chk("t6_held_dout",   ifc.DOUT,   8'h22);
        ifc.DREADY = 1'b1;
        tick();
        chk("t6_held_consumed", ifc.DVALID, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("t6_no_lock_7", ifc.LOCK, 1'b0);
        send_bit(1'b1);
        chk("t6_relock",  ifc.LOCK,   1'b1);
        chk("t6_no_word", ifc.DVALID, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        chk("t6_dvalid", ifc.DVALID, 1'b1);
        chk("t6_dout",   ifc.DOUT,   8'h77);
        idle();
        idle();

        chk("sync_never_out", saw_sync_out, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
